// File: rtl/core_block_controller_pkg.sv
// ============================================================================
// core_block_controller_pkg : shared types for the per-core block controller
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package core_block_controller_pkg;

  typedef logic [31:0] data_t;

  typedef struct packed {
    data_t threads_per_block;
  } kernel_config_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

  // One extra bit keeps ceil(0xFFFFFFFF / WARP_SIZE) from wrapping.
  function automatic logic [32:0] ceil_warps(input data_t threads, input int log2_ws);
    logic [32:0] sum;
    sum = {1'b0, threads} + ((33'd1 << log2_ws) - 33'd1);
    return sum >> log2_ws;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_block_controller_mask_gen.sv
// ============================================================================
// core_block_controller_mask_gen : lane-enable mask for the warp being launched
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module core_block_controller_mask_gen #(
  parameter int WARP_SIZE = 16
) (
  input  logic                         valid,
  input  logic                         last,
  input  logic [$clog2(WARP_SIZE)-1:0] partial,
  output logic [WARP_SIZE-1:0]         mask
);

  // partial == 0 means the block fills its last warp exactly (or was clamped).
  always_comb begin
    mask = '0;
    if (valid) begin
      for (int i = 0; i < WARP_SIZE; i++) begin
        mask[i] = !last || (partial == '0) || (i < int'(partial));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_block_controller.sv
// ============================================================================
// core_block_controller : accepts a block from the dispatcher, launches its
// warps one per cycle, gathers completions and holds done until reset.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module core_block_controller
  import core_block_controller_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WARP_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  data_t                block_id,
  input  data_t                threads_per_block,
  output data_t                block_idx,
  output logic [NUM_WARPS-1:0] warp_start,
  output data_t                warp_thread_base,
  output logic [WARP_SIZE-1:0] warp_active_mask,
  input  logic [NUM_WARPS-1:0] warp_done,
  output logic                 cfg_err,
  output logic                 done
);

  localparam int LANE_W = $clog2(WARP_SIZE);
  localparam int IDX_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_W  = $clog2(NUM_WARPS + 1);

  ctrl_state_t          state_q, state_d;
  data_t                block_idx_q, block_idx_d;
  logic [CNT_W-1:0]     nwarps_q, nwarps_d;
  logic [LANE_W-1:0]    partial_q, partial_d;
  logic [IDX_W-1:0]     widx_q, widx_d;
  logic [NUM_WARPS-1:0] launched_q, launched_d;
  logic [NUM_WARPS-1:0] done_seen_q, done_seen_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [32:0]          warps_needed;
  logic                 over_cap;
  logic                 launching;
  logic                 last_launch;
  logic [NUM_WARPS-1:0] launch_vec;

  assign warps_needed = ceil_warps(threads_per_block, LANE_W);
  assign over_cap     = warps_needed > 33'(NUM_WARPS);
  assign launching    = (state_q == LAUNCH);
  assign launch_vec   = launching ? (NUM_WARPS'(1) << widx_q) : '0;
  assign last_launch  = launching && ((32'(widx_q) + 32'd1) == 32'(nwarps_q));

  always_comb begin
    state_d     = state_q;
    block_idx_d = block_idx_q;
    nwarps_d    = nwarps_q;
    partial_d   = partial_q;
    widx_d      = widx_q;
    launched_d  = launched_q;
    done_seen_d = done_seen_q;
    cfg_err_d   = cfg_err_q;

    // A warp finishing in its own launch cycle still counts.
    if (state_q == LAUNCH || state_q == RUN) begin
      launched_d  = launched_q | launch_vec;
      done_seen_d = done_seen_q | (warp_done & (launched_q | launch_vec));
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          block_idx_d = block_id;
          launched_d  = '0;
          done_seen_d = '0;
          widx_d      = '0;
          if (over_cap) begin
            cfg_err_d = 1'b1;
            nwarps_d  = CNT_W'(NUM_WARPS);
            partial_d = '0;
          end else begin
            nwarps_d  = warps_needed[CNT_W-1:0];
            partial_d = threads_per_block[LANE_W-1:0];
          end
          // An empty block passes through RUN with nothing launched.
          state_d = (warps_needed == '0) ? RUN : LAUNCH;
        end
      end
      LAUNCH: begin
        if (last_launch) state_d = RUN;
        else             widx_d  = widx_q + 1'b1;
      end
      RUN: begin
        if ((done_seen_d & launched_q) == launched_q) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      block_idx_q <= '0;
      nwarps_q    <= '0;
      partial_q   <= '0;
      widx_q      <= '0;
      launched_q  <= '0;
      done_seen_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_idx_q <= block_idx_d;
      nwarps_q    <= nwarps_d;
      partial_q   <= partial_d;
      widx_q      <= widx_d;
      launched_q  <= launched_d;
      done_seen_q <= done_seen_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  core_block_controller_mask_gen #(
    .WARP_SIZE(WARP_SIZE)
  ) u_mask_gen (
    .valid  (launching),
    .last   (last_launch),
    .partial(partial_q),
    .mask   (warp_active_mask)
  );

  assign warp_start       = launch_vec;
  assign warp_thread_base = launching ? (32'(widx_q) << LANE_W) : '0;
  assign block_idx        = block_idx_q;
  assign cfg_err          = cfg_err_q;
  assign done             = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_core_block_controller.sv
// ============================================================================
// tb_core_block_controller : directed and randomized blocks checked against a
// timing-level reference model of the block controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_block_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] block_id = '0;
  logic [31:0] threads_per_block = '0;
  logic [3:0]  warp_done = '0;
  logic [31:0] block_idx;
  logic [3:0]  warp_start;
  logic [31:0] warp_thread_base;
  logic [15:0] warp_active_mask;
  logic        cfg_err;
  logic        done;

  core_block_controller #(.NUM_WARPS(4), .WARP_SIZE(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .block_id         (block_id),
    .threads_per_block(threads_per_block),
    .block_idx        (block_idx),
    .warp_start       (warp_start),
    .warp_thread_base (warp_thread_base),
    .warp_active_mask (warp_active_mask),
    .warp_done        (warp_done),
    .cfg_err          (cfg_err),
    .done             (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int a     = 0;
  int wd_mode = 0;
  bit chk_en  = 1'b0;

  // Model: a block accepted in cycle acc launches warp k in cycle acc+1+k and
  // raises done at max(acc+N+2, last completion cycle + 1).
  bit          m_active = 1'b0;
  int          m_acc = 0;
  int          m_n = 0;
  int          m_rem = 0;
  bit          m_cfg = 1'b0;
  logic [31:0] m_bid = '0;
  int          m_comp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    longint unsigned t;
    longint unsigned nw;
    if (reset) begin
      m_active = 1'b0;
    end else if (m_active) begin
      for (int k = 0; k < m_n; k++)
        if (m_comp[k] < 0 && warp_done[k] && cyc >= m_acc + 1 + k) m_comp[k] = cyc;
    end else if (start) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_bid    = block_id;
      t        = longint'(threads_per_block);
      nw       = (t + 15) / 16;
      if (nw > 4) begin
        m_cfg = 1'b1; m_n = 4; m_rem = 0;
      end else begin
        m_cfg = 1'b0; m_n = int'(nw); m_rem = int'(t % 16);
      end
      for (int k = 0; k < 4; k++) m_comp[k] = -1;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin : compare
    logic [3:0]  e_ws;
    logic [31:0] e_base;
    logic [15:0] e_mask;
    logic        e_done;
    logic        e_cfg;
    logic [31:0] e_bid;
    int k, lastc, dc;
    bit allc;
    if (chk_en) begin
      e_ws = '0; e_base = '0; e_mask = '0; e_done = 1'b0; e_cfg = 1'b0; e_bid = '0;
      if (m_active) begin
        k = cyc - m_acc - 1;
        e_bid = m_bid;
        e_cfg = m_cfg;
        if (k < m_n) begin
          e_ws   = 4'(1 << k);
          e_base = 32'(k * 16);
          e_mask = (k == m_n - 1 && m_rem != 0) ? 16'((1 << m_rem) - 1) : 16'hFFFF;
        end
        allc = 1'b1; lastc = -1;
        for (int j = 0; j < m_n; j++) begin
          if (m_comp[j] < 0) allc = 1'b0;
          else if (m_comp[j] > lastc) lastc = m_comp[j];
        end
        dc = m_acc + m_n + 2;
        if (lastc + 1 > dc) dc = lastc + 1;
        e_done = allc && (cyc >= dc);
      end
      chk("warp_start", 32'(warp_start), 32'(e_ws));
      chk("warp_thread_base", warp_thread_base, e_base);
      chk("warp_active_mask", 32'(warp_active_mask), 32'(e_mask));
      chk("done", 32'(done), 32'(e_done));
      chk("cfg_err", 32'(cfg_err), 32'(e_cfg));
      chk("block_idx", block_idx, e_bid);
    end
  end

  always @(posedge clk) begin
    #1;
    case (wd_mode)
      0: warp_done = '0;
      1: warp_done = 4'($urandom);
      2: warp_done = '1;
      default: ;
    endcase
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic go(input logic [31:0] bid, input logic [31:0] thr);
    @(posedge clk); #1;
    start = 1'b1; block_id = bid; threads_per_block = thr;
    a = cyc;
  endtask

  task automatic at_k(input int k);
    do @(negedge clk); while (cyc < a + k);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] thr;
    int sel;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_block_idx", block_idx, 32'd0);

    // Four full warps, instant completion.
    wd_mode = 2;
    go(32'd3, 32'd64);
    at_k(1); chk("t1_ws1", 32'(warp_start), 32'h1);
    at_k(2); chk("t1_ws2", 32'(warp_start), 32'h2);
    at_k(3); chk("t1_ws3", 32'(warp_start), 32'h4); chk("t1_base3", warp_thread_base, 32'd32);
    at_k(4); chk("t1_ws4", 32'(warp_start), 32'h8);
    at_k(5); chk("t1_done5", 32'(done), 32'd0);
    at_k(6); chk("t1_done6", 32'(done), 32'd1); chk("t1_bid", block_idx, 32'd3);

    // Partial last warp with a spurious completion on an unlaunched slot.
    do_reset(); wd_mode = 3; warp_done = '0;
    go(32'd1, 32'd20);
    at_k(1); warp_done = 4'b1000;
    at_k(2); chk("t2_mask2", 32'(warp_active_mask), 32'h000F); chk("t2_ws2", 32'(warp_start), 32'h2);
    warp_done = '0;
    at_k(3); chk("t2_ws3", 32'(warp_start), 32'h0);
    at_k(4); warp_done = 4'b0011; chk("t2_done4", 32'(done), 32'd0);
    at_k(5); warp_done = '0; chk("t2_done5", 32'(done), 32'd1);

    // Empty block.
    do_reset(); wd_mode = 0;
    go(32'd2, 32'd0);
    at_k(1); chk("t3_done1", 32'(done), 32'd0);
    at_k(2); chk("t3_done2", 32'(done), 32'd1); start = 1'b0;
    at_k(12); chk("t3_done12", 32'(done), 32'd1);

    // Oversized block is clamped.
    do_reset(); wd_mode = 1;
    go(32'd4, 32'd100);
    at_k(1); chk("t4_cfg", 32'(cfg_err), 32'd1);
    at_k(4); chk("t4_mask4", 32'(warp_active_mask), 32'hFFFF); chk("t4_ws4", 32'(warp_start), 32'h8);
    wait_done(100);

    // Early single completion, then reset in RUN.
    do_reset(); wd_mode = 3; warp_done = '0;
    go(32'd5, 32'd64);
    at_k(1); warp_done = 4'b0001;
    at_k(2); warp_done = '0;
    at_k(6); warp_done = 4'b0010;
    at_k(7); warp_done = '0; reset = 1'b1; start = 1'b0;
    at_k(8); reset = 1'b0;
    chk("t5_done_after_reset", 32'(done), 32'd0);
    at_k(12); chk("t5_no_launch", 32'(warp_start), 32'h0);

    // Back-to-back blocks from the dispatcher.
    do_reset(); wd_mode = 2;
    go(32'd7, 32'd32);
    wait_done(50);
    do_reset();
    go(32'd8, 32'd48);
    at_k(1); chk("t6_ws1", 32'(warp_start), 32'h1);
    wait_done(50);
    chk("t6_bid", block_idx, 32'd8);

    for (int it = 0; it < 25; it++) begin
      do_reset();
      sel = $urandom_range(0, 9);
      case (sel)
        0: thr = 32'd0;
        1: thr = 32'hFFFF_FFFF;
        2: thr = $urandom;
        3: thr = 32'd64;
        default: thr = 32'($urandom_range(1, 70));
      endcase
      wd_mode = $urandom_range(1, 2);
      go($urandom, thr);
      at_k($urandom_range(1, 3));
      start = 1'b0;
      wait_done(200);
      start = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    wd_mode = 0;
    do_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
